// File: rtl/image_blender_pkg.sv
// Shared command encodings and power-up configuration for the image blender pipe.
// The default weights of 1/1 with shift 0 make an unconfigured block average its inputs.
package image_blender_pkg;

  localparam logic [1:0] CMD_PIXEL        = 2'd0;
  localparam logic [1:0] CMD_LOAD_SHIFT   = 2'd1;
  localparam logic [1:0] CMD_LOAD_WEIGHTS = 2'd2;
  localparam logic [1:0] CMD_LOAD_ALPHA   = 2'd3;

  localparam int WA_RST    = 1;
  localparam int WB_RST    = 1;
  localparam int SHIFT_RST = 0;

endpackage

// File: rtl/blend_lane.sv
// One channel of the blender: stage-1 product registers, then a combinational
// add, divide-by-power-of-two and saturate that feeds the top-level output register.
module blend_lane #(
  parameter int PIX_W   = 8,
  parameter int WGT_W   = 8,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PIX_W-1:0]   a,
  input  logic [PIX_W-1:0]   b,
  input  logic [WGT_W-1:0]   wa,
  input  logic [WGT_W-1:0]   wb,
  input  logic [SHIFT_W-1:0] shift,
  output logic [PIX_W-1:0]   result
);

  localparam int PROD_W = PIX_W + WGT_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  logic [PROD_W-1:0]  prod_a;
  logic [PROD_W-1:0]  prod_b;
  logic [SUM_W-1:0]   sum;
  logic [SUM_W-1:0]   scaled;
  logic [SHIFT_W:0]   amt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_a <= '0;
      prod_b <= '0;
    end else if (load) begin
      prod_a <= PROD_W'(wa) * PROD_W'(a);
      prod_b <= PROD_W'(wb) * PROD_W'(b);
    end
  end

  // shift is the value captured alongside the products, so the divisor is 2^(shift+1)
  always_comb begin
    sum    = SUM_W'(prod_a) + SUM_W'(prod_b);
    amt    = (SHIFT_W+1)'(shift) + (SHIFT_W+1)'(1);
    scaled = (32'(amt) >= SUM_W) ? '0 : (sum >> amt);
    if (scaled > SUM_W'(PIX_MAX)) result = PIX_MAX;
    else                          result = scaled[PIX_W-1:0];
  end

endmodule

// File: rtl/image_blender_pipe.sv
// Two-stage weighted blender of two multi-channel pixel streams with in-band
// configuration beats; handshake and configuration live here, arithmetic in blend_lane.
module image_blender_pipe
  import image_blender_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int CH      = 3,
  parameter int WGT_W   = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          cmd,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*PIX_W-1:0] data_a,
  input  logic [CH*PIX_W-1:0] data_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*PIX_W-1:0] data_out
);

  localparam int DW = CH * PIX_W;
  localparam int AW = (1 << SHIFT_W) + WGT_W + 2;
  localparam logic [WGT_W-1:0] WGT_MAX = '1;

  logic [WGT_W-1:0]   wa;
  logic [WGT_W-1:0]   wb;
  logic [SHIFT_W-1:0] shift;
  logic [SHIFT_W-1:0] s1_shift;
  logic               s1_valid;
  logic               adv2;
  logic               accept;
  logic               pix_load;
  logic [SHIFT_W:0]   alpha_amt;
  logic [AW-1:0]      alpha_full;
  logic [AW-1:0]      alpha_wa;
  logic [AW-1:0]      alpha_diff;
  logic [WGT_W-1:0]   alpha_wb;
  logic [DW-1:0]      lane_out;

  assign adv2     = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | adv2;
  assign accept   = in_valid & in_ready;
  assign pix_load = accept & (cmd == CMD_PIXEL);

  // Alpha mode derives wb so that wa + wb equals the current divisor 2^(shift+1)
  always_comb begin
    alpha_amt  = (SHIFT_W+1)'(shift) + (SHIFT_W+1)'(1);
    alpha_full = AW'(1) << alpha_amt;
    alpha_wa   = AW'(data_a[WGT_W-1:0]);
    alpha_diff = alpha_full - alpha_wa;
    if (alpha_wa > alpha_full)           alpha_wb = '0;
    else if (alpha_diff > AW'(WGT_MAX))  alpha_wb = WGT_MAX;
    else                                 alpha_wb = alpha_diff[WGT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wa    <= WGT_W'(WA_RST);
      wb    <= WGT_W'(WB_RST);
      shift <= SHIFT_W'(SHIFT_RST);
    end else if (accept) begin
      case (cmd)
        CMD_LOAD_SHIFT: shift <= data_a[SHIFT_W-1:0];
        CMD_LOAD_WEIGHTS: begin
          wa <= data_a[WGT_W-1:0];
          wb <= data_b[WGT_W-1:0];
        end
        CMD_LOAD_ALPHA: begin
          wa <= data_a[WGT_W-1:0];
          wb <= alpha_wb;
        end
        default: ;
      endcase
    end
  end

  // Stage 1 refills whenever it is free or draining; config beats simply leave it empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_shift  <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      if (in_ready) s1_valid <= pix_load;
      if (pix_load) s1_shift <= shift;
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) data_out <= lane_out;
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    blend_lane #(
      .PIX_W   (PIX_W),
      .WGT_W   (WGT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (pix_load),
      .a      (data_a[c*PIX_W +: PIX_W]),
      .b      (data_b[c*PIX_W +: PIX_W]),
      .wa     (wa),
      .wb     (wb),
      .shift  (s1_shift),
      .result (lane_out[c*PIX_W +: PIX_W])
    );
  end

endmodule

// File: tb/tb_image_blender_pipe.sv
// Bench for image_blender_pipe: a queue-based reference model checked every cycle,
// directed beats with hand-computed results, then randomized traffic and backpressure.
module tb_image_blender_pipe;
  import image_blender_pkg::*;

  localparam int PIX_W   = 8;
  localparam int CH      = 3;
  localparam int WGT_W   = 8;
  localparam int SHIFT_W = 4;
  localparam int DW      = CH * PIX_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    cmd = 2'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data_a = '0;
  logic [DW-1:0] data_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] data_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit rand_ready = 1'b0;

  typedef struct { logic [DW-1:0] data; int acc; } exp_t;
  typedef struct { logic [DW-1:0] data; int cyc; } got_t;
  exp_t exp_q[$];
  got_t got_q[$];

  int m_wa    = 1;
  int m_wb    = 1;
  int m_shift = 0;

  image_blender_pipe #(
    .PIX_W(PIX_W), .CH(CH), .WGT_W(WGT_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_a    (data_a),
    .data_b    (data_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rep(input int v);
    logic [DW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*PIX_W +: PIX_W] = PIX_W'(v);
    return r;
  endfunction

  function automatic logic [DW-1:0] blend(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input int wa, input int wb, input int sh);
    logic [DW-1:0] r;
    longint s;
    longint v;
    for (int c = 0; c < CH; c++) begin
      s = longint'(wa) * longint'(a[c*PIX_W +: PIX_W]) + longint'(wb) * longint'(b[c*PIX_W +: PIX_W]);
      v = (sh + 1 >= PIX_W + WGT_W + 1) ? 0 : (s >>> (sh + 1));
      if (v > (1 << PIX_W) - 1) v = (1 << PIX_W) - 1;
      r[c*PIX_W +: PIX_W] = PIX_W'(v);
    end
    return r;
  endfunction

  // Reference model and per-cycle compare, sampled mid-cycle
  always @(negedge clk) begin : compare
    exp_t e;
    got_t g;
    logic exp_ov;
    logic exp_ir;
    int   t;
    if (!rst) begin
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_data_out", 64'(data_out), 64'd0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      m_wa = 1; m_wb = 1; m_shift = 0;
    end else begin
      exp_ov = (exp_q.size() > 0) && (exp_q[0].acc < cyc);
      exp_ir = !((exp_q.size() == 2) && !out_ready);
      checkOutput("out_valid", 64'(out_valid), 64'(exp_ov));
      checkOutput("in_ready", 64'(in_ready), 64'(exp_ir));
      if (out_valid && exp_ov) checkOutput("data_out", 64'(data_out), 64'(exp_q[0].data));
      if (out_valid && out_ready) begin
        g.data = data_out; g.cyc = cyc;
        got_q.push_back(g);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        case (cmd)
          2'd0: begin
            e.data = blend(data_a, data_b, m_wa, m_wb, m_shift);
            e.acc  = cyc + 1;
            exp_q.push_back(e);
          end
          2'd1: m_shift = int'(data_a[SHIFT_W-1:0]);
          2'd2: begin
            m_wa = int'(data_a[WGT_W-1:0]);
            m_wb = int'(data_b[WGT_W-1:0]);
          end
          default: begin
            m_wa = int'(data_a[WGT_W-1:0]);
            t = (1 << (m_shift + 1)) - m_wa;
            if (t < 0) t = 0;
            if (t > (1 << WGT_W) - 1) t = (1 << WGT_W) - 1;
            m_wb = t;
          end
        endcase
      end
    end
  end

  // Called at posedge+1; returns the edge number at which the beat was taken
  task automatic applyStimulus(input logic [1:0] c, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, output int acc);
    int n;
    cmd = c; data_a = a; data_b = b; in_valid = 1'b1; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    checkOutput("accept_within_bound", 64'(in_ready), 64'd1);
    acc = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expectBeat(input string name, input int v, input int exp_cyc);
    int n;
    got_t g;
    n = 0;
    while (got_q.size() == 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput({name, "_present"}, 64'(got_q.size() != 0), 64'd1);
    if (got_q.size() != 0) begin
      g = got_q.pop_front();
      checkOutput(name, 64'(g.data), 64'(rep(v)));
      if (exp_cyc >= 0) checkOutput({name, "_cycle"}, 64'(g.cyc), 64'(exp_cyc));
    end
    @(posedge clk); #1;
  endtask

  initial begin : out_ready_driver
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(3) != 0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int acc1, acc2, dummy, r;
    logic [1:0] c;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Default configuration averages
    applyStimulus(CMD_PIXEL, rep(10), rep(21), acc1);
    expectBeat("default_avg", 15, acc1 + 1);

    // Configured blend, back-to-back pixels
    applyStimulus(CMD_LOAD_SHIFT, DW'(3), '0, dummy);
    applyStimulus(CMD_LOAD_WEIGHTS, DW'(9), DW'(7), dummy);
    applyStimulus(CMD_PIXEL, rep(150), rep(50), acc1);
    applyStimulus(CMD_PIXEL, rep(255), rep(205), acc2);
    checkOutput("b2b_accept", 64'(acc2), 64'(acc1 + 1));
    expectBeat("blend_first", 106, acc1 + 1);
    expectBeat("blend_second", 233, acc1 + 2);

    // Saturation and large shift
    applyStimulus(CMD_LOAD_SHIFT, DW'(0), '0, dummy);
    applyStimulus(CMD_LOAD_WEIGHTS, DW'(200), DW'(200), dummy);
    applyStimulus(CMD_PIXEL, rep(255), rep(255), acc1);
    expectBeat("saturate", 255, acc1 + 1);
    applyStimulus(CMD_LOAD_SHIFT, DW'(15), '0, dummy);
    applyStimulus(CMD_PIXEL, rep(100), rep(100), acc1);
    expectBeat("shift15", 0, acc1 + 1);

    // Alpha mode, including negative and overflowing complements
    applyStimulus(CMD_LOAD_SHIFT, DW'(3), '0, dummy);
    applyStimulus(CMD_LOAD_ALPHA, DW'(12), '0, dummy);
    applyStimulus(CMD_PIXEL, rep(100), rep(20), acc1);
    expectBeat("alpha12", 80, acc1 + 1);
    applyStimulus(CMD_LOAD_ALPHA, DW'(20), '0, dummy);
    applyStimulus(CMD_PIXEL, rep(100), rep(20), acc1);
    expectBeat("alpha_neg_clamp", 125, acc1 + 1);
    applyStimulus(CMD_LOAD_SHIFT, DW'(8), '0, dummy);
    applyStimulus(CMD_LOAD_ALPHA, DW'(2), '0, dummy);
    applyStimulus(CMD_PIXEL, rep(0), rep(255), acc1);
    expectBeat("alpha_ovf_clamp", 127, acc1 + 1);

    // Backpressure with two pixels in flight
    applyStimulus(CMD_LOAD_SHIFT, DW'(0), '0, dummy);
    applyStimulus(CMD_LOAD_WEIGHTS, DW'(1), DW'(1), dummy);
    out_ready = 1'b0;
    applyStimulus(CMD_PIXEL, rep(10), rep(20), acc1);
    applyStimulus(CMD_PIXEL, rep(100), rep(200), acc2);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
    checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
    checkOutput("stall_data_out", 64'(data_out), 64'(rep(15)));
    out_ready = 1'b1;
    expectBeat("stall_first", 15, -1);
    expectBeat("stall_second", 150, -1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stall_no_duplicate", 64'(got_q.size()), 64'd0);

    // Weights loaded right behind a pixel do not affect it
    applyStimulus(CMD_PIXEL, rep(40), rep(60), acc1);
    applyStimulus(CMD_LOAD_WEIGHTS, DW'(3), DW'(1), dummy);
    applyStimulus(CMD_PIXEL, rep(40), rep(60), acc2);
    expectBeat("inflight_old_weights", 50, acc1 + 1);
    expectBeat("inflight_new_weights", 90, acc2 + 1);

    // Reset with two pixels in flight
    out_ready = 1'b0;
    applyStimulus(CMD_PIXEL, rep(1), rep(2), dummy);
    applyStimulus(CMD_PIXEL, rep(3), rep(4), dummy);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_flush", 64'(got_q.size()), 64'd0);
    applyStimulus(CMD_PIXEL, rep(10), rep(21), acc1);
    expectBeat("reset_defaults", 15, acc1 + 1);

    // Randomized traffic with random backpressure
    got_q.delete();
    rand_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(4) == 0) begin
        @(posedge clk); #1;
      end else begin
        r = $urandom_range(9);
        c = (r < 6) ? CMD_PIXEL : (r < 7) ? CMD_LOAD_SHIFT : (r < 8) ? CMD_LOAD_WEIGHTS : CMD_LOAD_ALPHA;
        if (c == CMD_LOAD_SHIFT) applyStimulus(c, DW'($urandom_range(9)), DW'($urandom()), dummy);
        else                     applyStimulus(c, DW'($urandom()), DW'($urandom()), dummy);
      end
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("random_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/image_blender_pipe.md
IMAGE_BLENDER_PIPE -- requirements
Module: image_blender_pipe

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, meaning the pixel component width in bits.
REQ-002 The block SHALL have parameter CH, default 3, meaning the number of independent channels blended per beat.
REQ-003 The block SHALL have parameter WGT_W, default 8, meaning the blend weight width, unsigned.
REQ-004 The block SHALL have parameter SHIFT_W, default 4, meaning the width of the divisor exponent field.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-007 Port rst SHALL be an input, 1 bit wide: the asynchronous active-low reset.
REQ-008 Port cmd SHALL be an input, 2 bits wide: the beat type, with 0=PIXEL, 1=LOAD_SHIFT, 2=LOAD_WEIGHTS, 3=LOAD_ALPHA.
REQ-009 Port in_valid SHALL be an input, 1 bit wide: the upstream beat valid.
REQ-010 Port in_ready SHALL be an output, 1 bit wide: the block accepts a beat this cycle.
REQ-011 Port data_a SHALL be an input, CH*PIX_W bits wide: pixel A, channel 0 in the LSBs; bits [WGT_W-1:0] are weight A, or the shift value in bits [SHIFT_W-1:0], on configuration beats.
REQ-012 Port data_b SHALL be an input, CH*PIX_W bits wide: pixel B; bits [WGT_W-1:0] are weight B on LOAD_WEIGHTS.
REQ-013 Port out_valid SHALL be an output, 1 bit wide: the blended pixel is valid.
REQ-014 Port out_ready SHALL be an input, 1 bit wide: the downstream accepts the blended pixel.
REQ-015 Port data_out SHALL be an output, CH*PIX_W bits wide: the blended pixel, with the same channel packing.

Function
REQ-016 A beat SHALL be accepted exactly when in_valid and in_ready are both 1 at a rising clk edge.
REQ-017 The block SHALL drive in_ready as (~s1_valid | ~out_valid | out_ready), where s1_valid marks an occupied stage 1; the pipe SHALL hold data in place while stalled, with no loss and no duplication.
REQ-018 An accepted LOAD_SHIFT SHALL set shift <= data_a[SHIFT_W-1:0] and SHALL produce no output.
REQ-019 An accepted LOAD_WEIGHTS SHALL set wa <= data_a[WGT_W-1:0] and wb <= data_b[WGT_W-1:0], and SHALL produce no output.
REQ-020 An accepted LOAD_ALPHA SHALL set wa <= data_a[WGT_W-1:0] and wb <= 2^(shift+1) - wa, using the current shift, clamped to 0 if negative and to 2^WGT_W-1 if it overflows; it SHALL produce no output.
REQ-021 An accepted PIXEL SHALL compute, per channel c, out_c = min(2^PIX_W-1, (wa*a_c + wb*b_c) >> (shift+1)).
REQ-022 The sum SHALL use PIX_W+WGT_W+1 bits, with no intermediate truncation.
REQ-023 A shift amount that is at least the sum width SHALL yield 0.
REQ-024 The pipeline SHALL have two stages: stage 1 registers the products together with the current shift; stage 2 registers the add, shift and saturate result into data_out.
REQ-025 The latency from PIXEL acceptance to out_valid SHALL be 2 cycles with no backpressure, at a throughput of 1 beat per cycle.
REQ-026 A configuration beat SHALL affect only PIXEL beats accepted after it; pixels already in flight SHALL keep the weights and shift captured at stage 1.
REQ-027 Configuration beats SHALL occupy no pipeline slot and SHALL create no bubble in the output stream.
REQ-028 data_out SHALL hold its value while out_valid=1 and out_ready=0.

Reset
REQ-029 While rst=0 the block SHALL force out_valid=0, data_out=0, both stage valids 0, wa=1, wb=1 and shift=0, so the power-up default is a plain average.
REQ-030 in_ready SHALL be 1 while rst=0.
REQ-031 A reset mid-stream SHALL discard in-flight pixels without emitting them, and SHALL restore the default configuration.

Structure
REQ-032 Shared package image_blender_pkg SHALL hold the cmd encodings (CMD_PIXEL, CMD_LOAD_SHIFT, CMD_LOAD_WEIGHTS, CMD_LOAD_ALPHA) and the reset defaults for weights and shift.
REQ-033 Sub-module blend_lane SHALL implement one channel's multiply, add, shift and saturate datapath, instantiated CH times by generate; the handshake and configuration registers SHALL stay in the top level.

Verification
REQ-034 Default config: rst pulse, then PIXEL a=10, b=21 on channel 0 -> data_out ch0 = 15 two cycles later.
REQ-035 Configured blend: LOAD_SHIFT 3, LOAD_WEIGHTS 9/7, then PIXEL a=150, b=50 -> 106; a=255, b=205 -> 233; back-to-back beats give one output per cycle.
REQ-036 Saturation: shift 0, weights 200/200, a=b=255 -> 255; shift 15 with any pixel -> 0.
REQ-037 Alpha mode: shift 3, LOAD_ALPHA 12 -> wb=4; PIXEL a=100, b=20 -> 80; LOAD_ALPHA 20 -> wb=0.
REQ-038 Backpressure: out_ready=0 for 3 cycles with 2 pixels in flight -> in_ready=0 and data_out stable; after release both pixels appear, in order, exactly once.
REQ-039 Config during flight and reset: LOAD_WEIGHTS issued right behind a pixel -> that pixel uses the old weights; rst asserted with 2 pixels in flight -> no output, and defaults are restored.
